// File: rtl/rt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rt_pkg
// Description : Shared ray-traversal constants and types for the hit stages.
// Revision    : 1.0 - initial release
// ============================================================================
package rt_pkg;

    localparam logic [31:0] FLOAT_POS_INF     = 32'h7f800000;
    localparam logic [31:0] FLOAT_EPS_DEFAULT = 32'h322bcc77;
    localparam int          TRI_W_DEFAULT     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } chst_state_t;

    typedef struct packed {
        logic                     hit;
        logic [31:0]              t;
        logic [TRI_W_DEFAULT-1:0] tri_id;
    } hit_rec_t;

endpackage
`default_nettype wire

// File: rtl/closest_hit_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : closest_hit_tracker_if
// Description : Candidate input and result output handshakes of the tracker.
// Revision    : 1.0 - initial release
// ============================================================================
interface closest_hit_tracker_if #(
    parameter int TRI_W = 16,
    parameter int CNT_W = 16
) ();

    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             in_hit;
    logic [31:0]      in_t;
    logic [TRI_W-1:0] in_tri_id;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_hit;
    logic [31:0]      out_t;
    logic [TRI_W-1:0] out_tri_id;
    logic [CNT_W-1:0] out_count;

    modport master (
        output start, in_valid, in_hit, in_t, in_tri_id, in_last, out_ready,
        input  in_ready, out_valid, out_hit, out_t, out_tri_id, out_count
    );

    modport slave (
        input  start, in_valid, in_hit, in_t, in_tri_id, in_last, out_ready,
        output in_ready, out_valid, out_hit, out_t, out_tri_id, out_count
    );

endinterface
`default_nettype wire

// File: rtl/closest_hit_tracker_hit_qualify.sv
`default_nettype none
// ============================================================================
// Module      : hit_qualify
// Description : Flags a contact as a new nearest-hit candidate (integer t compare).
// Revision    : 1.0 - initial release
// ============================================================================
module hit_qualify
    import rt_pkg::*;
#(
    parameter logic [31:0] T_MIN = FLOAT_EPS_DEFAULT
) (
    input  wire logic        i_hit,
    input  wire logic [31:0] i_t,
    input  wire logic [31:0] i_best_t,
    output logic             o_candidate
);

    // Non-negative IEEE singles order the same as their raw bit patterns.
    assign o_candidate = i_hit & ~i_t[31] & (i_t > T_MIN) & (i_t < i_best_t);

endmodule
`default_nettype wire

// File: rtl/closest_hit_tracker.sv
`default_nettype none
// ============================================================================
// Module      : closest_hit_tracker
// Description : Per-ray nearest-hit reducer with valid/ready result output.
// Revision    : 1.0 - initial release
// ============================================================================
module closest_hit_tracker
    import rt_pkg::*;
#(
    parameter int          TRI_W = 16,
    parameter logic [31:0] T_MIN = FLOAT_EPS_DEFAULT,
    parameter int          CNT_W = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    closest_hit_tracker_if.slave bus
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    chst_state_t      r_state;
    logic             r_out_valid;
    logic             r_best_hit;
    logic [31:0]      r_best_t;
    logic [TRI_W-1:0] r_best_id;
    logic [CNT_W-1:0] r_count;

    logic             w_xfer;
    logic             w_candidate;

    assign w_xfer = bus.in_valid & (r_state == ACCUM);

    hit_qualify #(
        .T_MIN (T_MIN)
    ) u_hit_qualify (
        .i_hit       (bus.in_hit),
        .i_t         (bus.in_t),
        .i_best_t    (r_best_t),
        .o_candidate (w_candidate)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_best_hit  <= 1'b0;
            r_best_t    <= FLOAT_POS_INF;
            r_best_id   <= '0;
            r_count     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state    <= ACCUM;
                        r_best_hit <= 1'b0;
                        r_best_t   <= FLOAT_POS_INF;
                        r_best_id  <= '0;
                        r_count    <= '0;
                    end
                end
                ACCUM: begin
                    // A restart wins over a same-cycle transfer, which is dropped.
                    if (bus.start) begin
                        r_best_hit <= 1'b0;
                        r_best_t   <= FLOAT_POS_INF;
                        r_best_id  <= '0;
                        r_count    <= '0;
                    end else if (w_xfer) begin
                        if (r_count != c_CNT_MAX) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (w_candidate) begin
                            r_best_hit <= 1'b1;
                            r_best_t   <= bus.in_t;
                            r_best_id  <= bus.in_tri_id;
                        end
                        if (bus.in_last) begin
                            r_state     <= REPORT;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = (r_state == ACCUM);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_hit    = r_best_hit;
    assign bus.out_t      = r_best_t;
    assign bus.out_tri_id = r_best_id;
    assign bus.out_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_closest_hit_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_closest_hit_tracker
// Description : Scoreboard bench for closest_hit_tracker with random rays.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_closest_hit_tracker;
    import rt_pkg::*;

    localparam logic [31:0] c_T_MIN = FLOAT_EPS_DEFAULT;
    localparam logic [31:0] c_INF   = FLOAT_POS_INF;

    typedef struct {
        logic        hit;
        logic [31:0] t;
        logic [15:0] id;
    } tr_t;

    typedef struct {
        logic        hit;
        logic [31:0] t;
        logic [15:0] id;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    tr_t  ray_q[$];
    exp_t sb[$];
    logic [31:0] last_t = 32'h3f800000;

    closest_hit_tracker_if #(.TRI_W(16), .CNT_W(16)) bus ();

    closest_hit_tracker #(
        .TRI_W (16),
        .T_MIN (c_T_MIN),
        .CNT_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: the nearest positive finite t above T_MIN among hits, first one on ties.
    function automatic exp_t model();
        exp_t e;
        e.hit = 1'b0;
        e.t   = c_INF;
        e.id  = 16'd0;
        foreach (ray_q[i]) begin
            if (ray_q[i].hit && ray_q[i].t > c_T_MIN && ray_q[i].t < c_INF) begin
                if (!e.hit || ray_q[i].t < e.t) begin
                    e.hit = 1'b1;
                    e.t   = ray_q[i].t;
                    e.id  = ray_q[i].id;
                end
            end
        end
        e.cnt = (ray_q.size() > 65535) ? 16'hffff : 16'(ray_q.size());
        return e;
    endfunction

    function automatic logic [31:0] rand_t();
        logic [31:0] v;
        case ($urandom % 12)
            0:       v = 32'hbf800000;
            1:       v = 32'h3089705f;
            2:       v = 32'h7fc00000;
            3:       v = c_INF;
            4:       v = c_T_MIN;
            5:       v = c_T_MIN + 32'd1;
            6:       v = last_t;
            7:       v = 32'h00000000;
            default: begin
                v = {1'b0, 8'd125 + 8'($urandom % 4), 23'($urandom)};
                last_t = v;
            end
        endcase
        return v;
    endfunction

    // Monitor: pops on the first out_valid cycle, then checks the result holds.
    logic prev_v = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else if (bus.out_valid) begin
            if (!prev_v) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                    cur.hit = bus.out_hit;
                    cur.t   = bus.out_t;
                    cur.id  = bus.out_tri_id;
                    cur.cnt = bus.out_count;
                end else begin
                    cur = sb.pop_front();
                    chk("out_hit", bus.out_hit, cur.hit);
                    chk("out_t", bus.out_t, cur.t);
                    chk("out_tri_id", bus.out_tri_id, cur.id);
                    chk("out_count", bus.out_count, cur.cnt);
                end
            end else begin
                chk("hold_out_hit", bus.out_hit, cur.hit);
                chk("hold_out_t", bus.out_t, cur.t);
                chk("hold_out_tri_id", bus.out_tri_id, cur.id);
                chk("hold_out_count", bus.out_count, cur.cnt);
            end
            chk("in_ready_in_report", bus.in_ready, 0);
            prev_v = 1'b1;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ray_q.delete();
        chk("in_ready_after_start", bus.in_ready, 1);
    endtask

    task automatic send(input logic h, input logic [31:0] t, input logic [15:0] id, input logic last);
        int gap;
        gap = ($urandom_range(0, 3) == 0) ? 1 : 0;
        repeat (gap) tick();
        bus.in_valid  = 1'b1;
        bus.in_hit    = h;
        bus.in_t      = t;
        bus.in_tri_id = id;
        bus.in_last   = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        ray_q.push_back('{hit: h, t: t, id: id});
        if (last) begin
            sb.push_back(model());
            chk("latency_out_valid", bus.out_valid, 1);
            chk("in_ready_fall", bus.in_ready, 0);
        end
    endtask

    task automatic restart_with_valid(input logic h, input logic [31:0] t, input logic [15:0] id);
        bus.start     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_hit    = h;
        bus.in_t      = t;
        bus.in_tri_id = id;
        bus.in_last   = 1'b0;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        ray_q.delete();
        chk("in_ready_after_restart", bus.in_ready, 1);
    endtask

    task automatic drain(input int hold, input bit start_in_window);
        bus.out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.start = (start_in_window && i == hold / 2);
            tick();
            chk("report_held", bus.out_valid, 1);
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_in_ready", bus.in_ready, 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_hit    = 1'b0;
        bus.in_t      = 32'd0;
        bus.in_tri_id = 16'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_hit", bus.out_hit, 0);
        chk("rst_out_t", bus.out_t, c_INF);
        chk("rst_out_tri_id", bus.out_tri_id, 0);
        chk("rst_out_count", bus.out_count, 0);
        rst = 1'b0;
        tick();

        // Basic nearest-hit ray
        do_start();
        send(1'b1, 32'h40400000, 16'd5, 1'b0);
        send(1'b1, 32'h3fc00000, 16'd9, 1'b0);
        send(1'b0, 32'h3f000000, 16'd2, 1'b0);
        send(1'b1, 32'h40000000, 16'd7, 1'b1);
        drain(2, 1'b0);

        // All rejected
        do_start();
        send(1'b1, 32'hbf800000, 16'd1, 1'b0);
        send(1'b1, 32'h3089705f, 16'd2, 1'b0);
        send(1'b1, 32'h7fc00000, 16'd3, 1'b0);
        send(1'b1, c_INF,        16'd4, 1'b0);
        send(1'b0, 32'h3f800000, 16'd5, 1'b1);
        drain(0, 1'b0);

        // Tie keeps the earlier triangle
        do_start();
        send(1'b1, 32'h40000000, 16'd3, 1'b0);
        send(1'b1, 32'h40000000, 16'd4, 1'b1);
        drain(1, 1'b0);

        // Back-pressure with an ignored start, then a start that is accepted
        do_start();
        send(1'b1, 32'h3f800000, 16'd11, 1'b1);
        drain(10, 1'b1);
        do_start();
        send(1'b1, 32'h40800000, 16'd12, 1'b1);
        drain(0, 1'b0);

        // Restart mid-ray with a colliding transfer
        do_start();
        send(1'b1, 32'h3f000000, 16'd20, 1'b0);
        send(1'b1, 32'h3f400000, 16'd21, 1'b0);
        restart_with_valid(1'b1, 32'h3dcccccd, 16'd22);
        send(1'b1, 32'h40000000, 16'd23, 1'b0);
        send(1'b1, 32'h40400000, 16'd24, 1'b1);
        drain(0, 1'b0);

        // Asynchronous reset between clock edges
        do_start();
        send(1'b1, 32'h3f000000, 16'd30, 1'b0);
        send(1'b1, 32'h3e800000, 16'd31, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("arst_in_ready", bus.in_ready, 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_hit", bus.out_hit, 0);
        chk("arst_out_t", bus.out_t, c_INF);
        chk("arst_out_tri_id", bus.out_tri_id, 0);
        chk("arst_out_count", bus.out_count, 0);
        #2 rst = 1'b0;
        ray_q.delete();
        repeat (3) tick();
        chk("arst_no_out_valid", bus.out_valid, 0);
        chk("arst_idle", bus.in_ready, 0);

        // Random rays
        for (int r = 0; r < 60; r++) begin
            int n;
            n = $urandom_range(1, 8);
            do_start();
            for (int i = 0; i < n; i++) begin
                send(($urandom % 4) != 0, rand_t(), 16'($urandom), i == n - 1);
            end
            drain($urandom_range(0, 3), ($urandom % 2) == 1);
        end

        repeat (2) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/closest_hit_tracker.md
# closest_hit_tracker

Per-ray closest-hit reducer downstream of the triangle contact-detect stage. It consumes one accept/reject flag per tested triangle, together with that triangle's hit distance `t` and its ID, and keeps the nearest valid hit. After the last triangle of a ray it presents the winning `t` and triangle ID to the shading stage on a valid/ready handshake.

## Interface
- `TRI_W`, default 16: triangle ID width.
- `T_MIN`, default 32'h322bcc77 (1e-8): minimum accepted `t`. A candidate must satisfy `t > T_MIN` (strict).
- `CNT_W`, default 16: width of the tested-triangle counter.
- `clk` input, 1: clock.
- `rst` input, 1: asynchronous, active-high reset.
- `start` input, 1: begin a new ray. Clears the accumulator.
- `in_valid` input, 1: a candidate is present.
- `in_ready` output, 1: the block accepts a candidate this cycle.
- `in_hit` input, 1: contact-detect result (1 = inside triangle, non-degenerate).
- `in_t` input, 32: IEEE-754 single-precision hit distance.
- `in_tri_id` input, `TRI_W`: triangle ID.
- `in_last` input, 1: final triangle of the current ray.
- `out_valid` output, 1: the result is held and stable.
- `out_ready` input, 1: the downstream stage consumes the result.
- `out_hit` output, 1: at least one candidate was accepted.
- `out_t` output, 32: nearest accepted `t`. Holds 32'h7f800000 (+inf) when `out_hit` is 0.
- `out_tri_id` output, `TRI_W`: ID of the nearest accepted triangle. Holds 0 when `out_hit` is 0.
- `out_count` output, `CNT_W`: number of candidates transferred for this ray. Saturates at all-ones.

## Operation
- FSM states: IDLE, ACCUM, REPORT. Reset state is IDLE.
- IDLE:
  - `in_ready` = 0 and `out_valid` = 0.
  - `start` moves to ACCUM and sets best_t = +inf, best_id = 0, best_hit = 0, count = 0.
- ACCUM:
  - `in_ready` = 1. A transfer occurs when `in_valid & in_ready`.
  - Every transfer increments count (saturating at all-ones).
  - A transfer is a candidate only if all of these hold: `in_hit` = 1; `in_t[31]` = 0; `in_t > T_MIN`; `in_t < best_t`.
  - `t` comparisons are unsigned 32-bit integer comparisons. This ordering is exact for non-negative IEEE values.
  - Because of the integer compare, NaN and +inf never win: NaN compares above +inf, and the `< best_t` test against the initial +inf rejects +inf itself.
  - A candidate updates best_t, best_id and best_hit (set to 1) at the end of the same cycle. The next transfer compares against the updated value, which gives back-to-back throughput of 1 per cycle.
  - Ties (equal `t`) keep the earlier triangle, because the compare is strict.
  - A transfer with `in_last` = 1 is evaluated normally, then the FSM moves to REPORT.
  - `start` asserted in ACCUM re-initialises the accumulator and stays in ACCUM. Any transfer in that same cycle is discarded: `start` has priority, and the discarded transfer is not counted.
- REPORT:
  - `in_ready` = 0 and `out_valid` = 1.
  - The `out_*` signals show the registered best values and do not change while `out_valid` = 1.
  - `out_valid & out_ready` moves to IDLE.
  - `start` in REPORT is ignored; the upstream stage must wait.
- Reset is asynchronous and may arrive mid-ray. It forces IDLE, best_t = +inf, best_id = 0, best_hit = 0, count = 0. The partial result is lost and no `out_valid` is produced.

## Timing
- Output values after reset: `in_ready` 0, `out_valid` 0, `out_hit` 0, `out_t` 32'h7f800000, `out_tri_id` 0, `out_count` 0.
- Latency from the `in_last` transfer (cycle N) to `out_valid` = 1 is 1 cycle (cycle N+1).
- `in_ready` falls in cycle N+1.
- `out_valid` and `out_ready` high in the same cycle gives IDLE the next cycle. The earliest new `start` is that IDLE cycle, so there is a minimum of one dead cycle between rays.
- A ray with a single transfer takes 3 cycles minimum: the `start` cycle, the transfer cycle and the REPORT cycle.
- Every output is driven from a register. There is no combinational path from input to output except `in_ready`, which is a decode of the state register.

## Structure
- Shared package `rt_pkg` holds:
  - `FLOAT_POS_INF` = 32'h7f800000
  - `FLOAT_EPS_DEFAULT` = 32'h322bcc77
  - typedef `chst_state_t` enum {IDLE, ACCUM, REPORT}
  - typedef `hit_rec_t` struct {hit, t, tri_id}
- Natural sub-module: `hit_qualify`. It is combinational and computes the candidate flag from in_hit, in_t, T_MIN and best_t. It is reused by the shadow-ray any-hit path.
- No float IP is needed; the compare is integer only.

## Test plan
- Sequence: `start`; triangles (hit, t, id) = (1, 3.0 = 32'h40400000, 5), (1, 1.5 = 32'h3fc00000, 9), (0, 0.5, 2), and last (1, 2.0, 7). Required: `out_hit` 1, `out_t` 32'h3fc00000, `out_tri_id` 9, `out_count` 4, `out_valid` one cycle after the last transfer.
- Rejects: `t` = -1.0 (32'hbf800000), `t` = 1e-9 (32'h3089705f), NaN (32'h7fc00000), +inf, and a miss flagged last. Required: `out_hit` 0, `out_t` 32'h7f800000, `out_tri_id` 0, `out_count` 5.
- Tie: two hits with `t` = 2.0 and ids 3 then 4. Required: `out_tri_id` 3.
- Back-pressure: `out_ready` held low for 10 cycles in REPORT. Required: outputs stable and `in_ready` 0 throughout. `start` in this window is ignored; a `start` issued after the handshake is accepted.
- Restart: in ACCUM after 2 transfers, assert `start` together with `in_valid` (t = 0.1). Required: that transfer is discarded; the following ray counts from 0 and the result excludes the earlier hits.
- Asynchronous `rst` pulse mid-ACCUM, between clock edges. Required: immediate IDLE, all outputs at their reset values, and no `out_valid` produced.
